instr_fetch_unit: RTL

Fetch stage sitting directly downstream of the programme counter in the pipelined RV32I core. Owns the sequential fetch address, issues word reads to instruction memory over a valid/ready request channel with in-order responses, buffers returned instructions with their PCs in a small FIFO, and presents them to decode over a valid/ready handshake. A redirect from execute (branch/jump) replaces the fetch address, flushes the buffer and discards in-flight responses.

---
 rtl/ifu_pkg.sv | 20 ++
 rtl/ifu_fifo.sv | 86 ++++++++
 rtl/instr_fetch_unit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// ---------------------------------------------------------------------------
// ifu_pkg
// Shared types and constants for the instruction fetch unit.
//   XLEN      : architectural word / address width
//   PC_STEP   : byte distance between sequential instructions
//   NOP_INSTR : canonical RV32I NOP (addi x0, x0, 0)
//   ifu_entry_t : buffered {pc, instr} pair held in the fetch FIFO
// ---------------------------------------------------------------------------
package ifu_pkg;

    localparam int              XLEN      = 32;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } ifu_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// ---------------------------------------------------------------------------
// ifu_fifo
// Synchronous FIFO with flush, used to buffer fetched {pc, instr} entries.
// Output is registered storage (no write-through bypass): an entry pushed in
// cycle N is visible at the head in cycle N+1.
// Parameters:
//   DEPTH : number of entries, power of two, >= 2
//   WIDTH : entry width in bits
// Ports:
//   clk, rstn     : clock, synchronous active-low reset
//   flush_i       : discard all entries (push and pop ignored this cycle)
//   push_i        : write push_data_i at the tail
//   push_data_i   : entry to write
//   pop_i         : remove the head entry
//   head_o        : current head entry (undefined when empty)
//   empty_o       : no entries stored
//   count_o       : number of entries stored (0..DEPTH)
// ---------------------------------------------------------------------------
module ifu_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop, full;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push_i && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data-only; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage of the pipelined RV32I core. Issues sequential word reads to
// instruction memory (valid/ready request, in-order responses), buffers the
// returned words with their PCs and hands them to decode (valid/ready).
// A redirect from execute retargets fetch, flushes the buffer and marks every
// outstanding response as stale so it is dropped on arrival.
//
// Optional feature macro: IFU_MISALIGN_TRAP_EN
//   defined   : a redirect to a non-word-aligned target stops fetching and
//               presents a single sticky entry (if_misalign=1, if_pc=target,
//               if_instr=NOP) until the next redirect.
//   undefined : if_misalign is absent and redirect_addr[1:0] are ignored.
//
// Parameters:
//   RESET_ADDR : first fetch address after reset
//   FIFO_DEPTH : buffer entries and max requests in flight (power of two, >= 2)
// Ports:
//   clk, rstn                       : clock, synchronous active-low reset
//   redirect_valid, redirect_addr   : replace fetch stream this cycle
//   imem_req_valid/ready/addr       : memory read request channel
//   imem_rsp_valid/data             : in-order read responses
//   if_valid/ready                  : handshake to decode
//   if_instr, if_pc, if_pc_next     : instruction, its PC and PC+4
//   if_misalign                     : misaligned redirect target (feature only)
// ---------------------------------------------------------------------------
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_addr,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_next
`ifdef IFU_MISALIGN_TRAP_EN
    ,
    output logic            if_misalign
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   stale_q, stale_d;
    logic            trap_q, trap_d;
    logic [XLEN-1:0] redir_tgt;

    logic            fifo_empty, fifo_push, fifo_pop;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     used;
    logic            credit_ok, req_fire, rsp_keep;
    ifu_entry_t      push_entry, head;

`ifdef IFU_MISALIGN_TRAP_EN
    assign redir_tgt = redirect_addr;
    assign trap_d    = redirect_valid ? (redirect_addr[1:0] != 2'b00) : trap_q;
`else
    logic unused_redir_lsbs;
    assign unused_redir_lsbs = ^redirect_addr[1:0];
    assign redir_tgt         = {redirect_addr[XLEN-1:2], 2'b00};
    assign trap_d            = 1'b0;
`endif

    // Every slot is either buffered or reserved by an outstanding request, so
    // the FIFO can never overflow. A pop this cycle frees its slot right away,
    // which is what sustains one instruction per cycle at FIFO_DEPTH == 2.
    assign used      = {1'b0, inflight_q} + {1'b0, fifo_count} - (CW+1)'(fifo_pop);
    assign credit_ok = (used < (CW+1)'(FIFO_DEPTH));

    assign imem_req_valid = rstn && !redirect_valid && !trap_q && credit_ok;
    assign imem_req_addr  = fetch_addr_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A live response arriving together with a redirect is dropped as well.
    assign rsp_keep   = imem_rsp_valid && (stale_q == '0) && !redirect_valid;
    assign fifo_push  = rsp_keep;
    assign fifo_pop   = !fifo_empty && if_ready && !redirect_valid;
    assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};

    always_comb begin
        fetch_addr_d = fetch_addr_q;
        rsp_pc_d     = rsp_pc_q;
        stale_d      = stale_q;
        inflight_d   = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
        if (redirect_valid) begin
            fetch_addr_d = redir_tgt;
            rsp_pc_d     = redir_tgt;
            // Everything still outstanding after this cycle belongs to the old stream.
            stale_d      = inflight_d;
        end else begin
            if (req_fire) fetch_addr_d = fetch_addr_q + PC_STEP;
            if (imem_rsp_valid && (stale_q != '0)) stale_d = stale_q - CW'(1);
            if (rsp_keep) rsp_pc_d = rsp_pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            fetch_addr_q <= RESET_ADDR;
            rsp_pc_q     <= RESET_ADDR;
            inflight_q   <= '0;
            stale_q      <= '0;
            trap_q       <= 1'b0;
        end else begin
            fetch_addr_q <= fetch_addr_d;
            rsp_pc_q     <= rsp_pc_d;
            inflight_q   <= inflight_d;
            stale_q      <= stale_d;
            trap_q       <= trap_d;
        end
    end

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(ifu_entry_t))
    ) u_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .flush_i     (redirect_valid),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .head_o      (head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Outputs are forced to zero when nothing is presented so decode never
    // sees stale storage contents. While trapped, fetch_addr_q holds the
    // misaligned target because no request can fire.
    always_comb begin
        if_valid = 1'b0;
        if_instr = '0;
        if_pc    = '0;
        if (trap_q) begin
            if_valid = 1'b1;
            if_instr = NOP_INSTR;
            if_pc    = fetch_addr_q;
        end else if (!fifo_empty) begin
            if_valid = 1'b1;
            if_instr = head.instr;
            if_pc    = head.pc;
        end
    end

    assign if_pc_next = if_pc + PC_STEP;

`ifdef IFU_MISALIGN_TRAP_EN
    assign if_misalign = trap_q;
`endif

    // A response with nothing outstanding means memory broke the protocol.
    always @(posedge clk) begin
        if (rstn && imem_rsp_valid) begin
            assert (inflight_q != '0)
                else $error("instr_fetch_unit: response with no request outstanding");
        end
    end

endmodule
